// File: rtl/insn_encoder.sv
// RV32I instruction encoder: packs opcode/register/funct/immediate fields into a word,
// with a registered output stage and a one-entry skid buffer. Optional INSN_ENC_RANGE_CHECK_EN flags out-of-range immediates.
module insn_encoder #(
  parameter int DWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic              err_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t      state;
  logic [31:0] enc_insn;
  logic        enc_err;
  logic [31:0] skid_insn;
  logic        skid_err;
  logic        accept;
  logic        release_out;

  logic is_shift;
  assign is_shift = (opcode_i == OP_IMM) && (funct3_i == 3'b001 || funct3_i == 3'b101);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    enc_insn = NOP;
    enc_err  = 1'b0;
    unique case (opcode_i)
      OP_R: enc_insn = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        if (is_shift) begin
          enc_insn = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
`ifdef INSN_ENC_RANGE_CHECK_EN
          enc_err  = |imm_i[31:5];
`endif
        end else begin
          enc_insn = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
`ifdef INSN_ENC_RANGE_CHECK_EN
          enc_err  = !(&imm_i[31:11] || ~|imm_i[31:11]);
`endif
        end
      end
      OP_STORE: begin
        enc_insn = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
`ifdef INSN_ENC_RANGE_CHECK_EN
        enc_err  = !(&imm_i[31:11] || ~|imm_i[31:11]);
`endif
      end
      OP_BRANCH: begin
        enc_insn = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                    imm_i[4:1], imm_i[11], opcode_i};
`ifdef INSN_ENC_RANGE_CHECK_EN
        // A 13-bit signed even offset covers exactly [-4096, 4094].
        enc_err  = !(&imm_i[31:12] || ~|imm_i[31:12]) || imm_i[0];
`endif
      end
      OP_LUI, OP_AUIPC: begin
        enc_insn = {imm_i[31:12], rd_i, opcode_i};
`ifdef INSN_ENC_RANGE_CHECK_EN
        enc_err  = |imm_i[11:0];
`endif
      end
      OP_JAL: begin
        enc_insn = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
`ifdef INSN_ENC_RANGE_CHECK_EN
        enc_err  = !(&imm_i[31:20] || ~|imm_i[31:20]) || imm_i[0];
`endif
      end
      default: begin
        enc_insn = NOP;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign accept      = in_valid_i && in_ready_o;
  assign release_out = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: both data registers are reset too, since reset must clear held words and insn_o.
    if (!rst_ni) begin
      state       <= EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      insn_o      <= '0;
      err_o       <= 1'b0;
      skid_insn   <= '0;
      skid_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      unique case (state)
        EMPTY: begin
          if (accept) begin
            insn_o      <= enc_insn;
            err_o       <= enc_err;
            out_valid_o <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (accept && release_out) begin
            insn_o <= enc_insn;
            err_o  <= enc_err;
          end else if (accept) begin
            skid_insn  <= enc_insn;
            skid_err   <= enc_err;
            in_ready_o <= 1'b0;
            state      <= FULL;
          end else if (release_out) begin
            out_valid_o <= 1'b0;
            state       <= EMPTY;
          end
        end
        FULL: begin
          if (release_out) begin
            insn_o     <= skid_insn;
            err_o      <= skid_err;
            in_ready_o <= 1'b1;
            state      <= BUSY;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/insn_encoder.md
# insn_encoder

- Pipelined RV32I instruction encoder: packs opcode, register, funct and immediate fields into a 32-bit instruction word.
- Inverse of the decode-side immediate generator; places each immediate bit back into its type-specific position.
- Used by the self-test stimulus path and the instruction-memory preload engine; sits between a field producer and an instruction sink.
- Valid/ready handshake on both sides; one registered output stage plus a one-entry skid buffer.

## Interface
- DWIDTH, 32, instruction word width (only 32 supported)
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  field set valid
- in_ready_o  out  1  encoder can accept a field set
- opcode_i  in  7  major opcode
- rd_i, rs1_i, rs2_i  in  5 each  register indices
- funct3_i  in  3  funct3
- funct7_i  in  7  funct7 (R-type; shift-immediate upper bits)
- imm_i  in  32  immediate as a 32-bit signed/raw value
- out_valid_o  out  1  insn_o/err_o valid
- out_ready_i  in  1  sink accepts
- insn_o  out  DWIDTH  encoded instruction
- err_o  out  1  encoding error flag for this word

## Operation
- Accept when in_valid_i && in_ready_o. Release when out_valid_o && out_ready_i.
- Encoding by opcode_i; opcode always goes to [6:0]:
  - 0110011 R: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7].
  - 0010011, 0000011, 1100111, 1110011 I: imm[11:0]→[31:20], rs1, funct3, rd. Exception: 0010011 with funct3 001/101 places funct7→[31:25] and imm[4:0]→[24:20].
  - 0100011 S: imm[11:5]→[31:25], rs2, rs1, funct3, imm[4:0]→[11:7].
  - 1100011 B: imm[12]→31, imm[10:5]→[30:25], rs2, rs1, funct3, imm[4:1]→[11:8], imm[11]→7.
  - 0110111, 0010111 U: imm[31:12]→[31:12], rd.
  - 1101111 J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12], rd.
  - Any other opcode: insn = 32'h0000_0013 (NOP), err_o = 1.
- Fields unused by a type are ignored; bits not listed are always taken from the listed source, never from stray inputs.
- Buffer states:
  - EMPTY: out_valid_o=0, in_ready_o=1. Accept → BUSY.
  - BUSY: output register holds a word, in_ready_o=1.
    - Accept and release together → stay BUSY; the new word replaces the output.
    - Accept without release → FULL; the new word goes to the skid register.
    - Release only → EMPTY.
  - FULL: in_ready_o=0. Release → BUSY; the skid word moves to the output.
- Order is strictly preserved. No word is ever dropped or duplicated.

## Timing
- Latency: an accepted set appears on insn_o/err_o with out_valid_o in the next cycle (EMPTY or BUSY-with-release).
- Throughput: one word per cycle while out_ready_i=1.
- in_ready_o comes directly from a register (!skid_valid). No combinational path from out_ready_i.
- insn_o and err_o are stable while out_valid_o=1 && out_ready_i=0.
- Reset values: out_valid_o=0, insn_o=0, err_o=0, in_ready_o=1, state EMPTY, skid cleared.
- Reset asserted mid-operation discards both held words asynchronously.
- First acceptance is possible on the first rising edge after rst_ni deasserts.

## Configuration
- INSN_ENC_RANGE_CHECK_EN defined: err_o is also set for immediates that do not fit their type:
  - I/S: imm[31:11] not all equal.
  - Shift: imm[31:5]≠0.
  - B: outside [-4096,4094] or imm[0]=1.
  - J: imm[31:20] not all equal or imm[0]=1.
  - U: imm[11:0]≠0.
  - The word is still encoded from the truncated fields.
- Not defined: no range checks. err_o is set only for unknown opcodes, and the checking logic is absent.

## Test plan
- addi x1,x0,5 (0010011, rd=1, rs1=0, f3=0, imm=5), out_ready_i=1 → next cycle insn_o=0x00500093, err_o=0.
- sw x2,-4(x3) (0100011, f3=010, rs1=3, rs2=2, imm=-4) → 0xFE21AE23. jal x1,2048 (1101111, rd=1, imm=0x800) → 0x001000EF.
- Unknown opcode 7'h7F → insn_o=0x00000013, err_o=1, in both configurations.
- addi x1,x0,4096 → insn_o=0x00000093. err_o=1 with INSN_ENC_RANGE_CHECK_EN, 0 without. B-type with imm=3 → err_o=1 only with the macro.
- Backpressure: out_ready_i=0, three consecutive valid sets A, B, C → A and B accepted, in_ready_o=0 the cycle after B, C held. Raise out_ready_i → A, B, C delivered in order on consecutive cycles.
- FULL state, drop rst_ni mid-cycle → out_valid_o=0 and in_ready_o=1 immediately. After release nothing stale is emitted.
